// File: rtl/uart_tx_param.sv
// uart_tx_param: parameterised UART transmitter (start, DATA_BITS data LSB first,
// optional parity, STOP_BITS stop bits). All outputs are registered.
// Optional feature: define UART_TX_PARITY_EN to insert a parity bit after the data
// bits (even parity when PARITY_ODD = 0, odd parity when PARITY_ODD = 1).
`timescale 1ns/1ps

module uart_tx_param #(
    parameter int CLK_FREQ_HZ = 100000000,
    parameter int BAUD        = 9600,
    parameter int DATA_BITS   = 8,
    parameter int STOP_BITS   = 1,
    parameter int PARITY_ODD  = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 TxD,
    output logic                 tx_busy,
    output logic                 tx_done
);

    // Bit period rounded to the nearest whole clock.
    localparam int CLKS_PER_BIT = (CLK_FREQ_HZ + BAUD / 2) / BAUD;
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W        = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd4
`ifdef UART_TX_PARITY_EN
        ,
        PARITY = 3'd3
`endif
    } state_t;

    state_t               state_reg;
    logic [CNT_W-1:0]     baud_cnt_reg;
    logic [BIT_W-1:0]     bit_cnt_reg;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 txd_reg;
    logic                 tx_ready_reg;
    logic                 tx_busy_reg;
    logic                 tx_done_reg;
`ifdef UART_TX_PARITY_EN
    logic                 parity_reg;
    logic                 parity_next;

    // Parity of the incoming character, computed at accept so later tx_data changes cannot matter.
    assign parity_next = (^tx_data) ^ (PARITY_ODD != 0);
`endif

    logic bit_end;
    assign bit_end = (baud_cnt_reg == LAST_CNT);

    // Baud counter: idles at 0, free-runs 0..CLKS_PER_BIT-1 while a frame is on the line.
    always_ff @(posedge clk) begin
        if (reset || state_reg == IDLE) begin
            baud_cnt_reg <= '0;
        end else if (bit_end) begin
            baud_cnt_reg <= '0;
        end else begin
            baud_cnt_reg <= baud_cnt_reg + 1'b1;
        end
    end

    // Frame sequencer; line level and handshake outputs are updated together with the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            bit_cnt_reg  <= '0;
            shift_reg    <= '0;
            txd_reg      <= 1'b1;
            tx_ready_reg <= 1'b1;
            tx_busy_reg  <= 1'b0;
            tx_done_reg  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_reg   <= 1'b0;
`endif
        end else begin
            tx_done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    txd_reg <= 1'b1;
                    if (tx_valid && tx_ready_reg) begin
                        state_reg    <= START;
                        shift_reg    <= tx_data;
                        bit_cnt_reg  <= '0;
                        txd_reg      <= 1'b0;
                        tx_ready_reg <= 1'b0;
                        tx_busy_reg  <= 1'b1;
`ifdef UART_TX_PARITY_EN
                        parity_reg   <= parity_next;
`endif
                    end
                end
                START: begin
                    if (bit_end) begin
                        state_reg <= DATA;
                        txd_reg   <= shift_reg[0];
                        shift_reg <= shift_reg >> 1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_cnt_reg == LAST_DATA) begin
                            bit_cnt_reg <= '0;
`ifdef UART_TX_PARITY_EN
                            state_reg   <= PARITY;
                            txd_reg     <= parity_reg;
`else
                            state_reg   <= STOP;
                            txd_reg     <= 1'b1;
`endif
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + 1'b1;
                            txd_reg     <= shift_reg[0];
                            shift_reg   <= shift_reg >> 1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        state_reg <= STOP;
                        txd_reg   <= 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        if (bit_cnt_reg == LAST_STOP) begin
                            state_reg    <= IDLE;
                            bit_cnt_reg  <= '0;
                            tx_ready_reg <= 1'b1;
                            tx_busy_reg  <= 1'b0;
                            tx_done_reg  <= 1'b1;
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg    <= IDLE;
                    bit_cnt_reg  <= '0;
                    txd_reg      <= 1'b1;
                    tx_ready_reg <= 1'b1;
                    tx_busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign TxD      = txd_reg;
    assign tx_ready = tx_ready_reg;
    assign tx_busy  = tx_busy_reg;
    assign tx_done  = tx_done_reg;

endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: self-checking bench for uart_tx_param. Two instances at 10 clk/bit:
// unit 0 = 8 data bits, 1 stop, even parity sense; unit 1 = 5 data bits, 2 stops, odd sense.
// Expected line levels come from a per-bit frame model; follows UART_TX_PARITY_EN.
`timescale 1ns/1ps

module tb_uart_tx_param;

    localparam int CPB = 10;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] tv = 2'b00;
    logic [7:0] td8 = 8'h00;
    logic [4:0] td5 = 5'h00;
    logic [1:0] rdy, txd, bsy, dn;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    uart_tx_param #(.CLK_FREQ_HZ(1000000), .BAUD(100000), .DATA_BITS(8),
                    .STOP_BITS(1), .PARITY_ODD(0)) dut (
        .clk(clk), .reset(reset), .tx_valid(tv[0]), .tx_data(td8),
        .tx_ready(rdy[0]), .TxD(txd[0]), .tx_busy(bsy[0]), .tx_done(dn[0]));

    uart_tx_param #(.CLK_FREQ_HZ(1000000), .BAUD(100000), .DATA_BITS(5),
                    .STOP_BITS(2), .PARITY_ODD(1)) dut5 (
        .clk(clk), .reset(reset), .tx_valid(tv[1]), .tx_data(td5),
        .tx_ready(rdy[1]), .TxD(txd[1]), .tx_busy(bsy[1]), .tx_done(dn[1]));

    function automatic int nbits_of(input int u);
        return (u == 0) ? 8 : 5;
    endfunction

    function automatic int stops_of(input int u);
        return (u == 0) ? 1 : 2;
    endfunction

    function automatic int odd_of(input int u);
        return (u == 0) ? 0 : 1;
    endfunction

    // Line level of bit slot k of a frame: start, data LSB first, optional parity, stops.
    function automatic logic exp_bit(input int data, input int nbits, input int odd, input int k);
        int ones;
        ones = 0;
        if (k == 0) return 1'b0;
        if (k <= nbits) return data[k-1];
        if (PAR == 1 && k == nbits + 1) begin
            for (int i = 0; i < nbits; i++) ones += data[i];
            return ((ones + odd) % 2) == 1;
        end
        return 1'b1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int u, input int data);
        if (u == 0) td8 = data[7:0];
        else        td5 = data[4:0];
    endtask

    // Present one character, check every bit slot and the completion cycle.
    // Returns in the first idle cycle; with hold, tx_valid stays high there.
    task automatic play_frame(input int u, input int data, input bit hold);
        int nb, bad_line, bad_stat;
        logic eb;
        nb = 1 + nbits_of(u) + PAR + stops_of(u);
        vectors++;
        if (rdy[u] !== 1'b1) begin
            miscompares++;
            $display("FAIL ready_before_accept u%0d: got %b want 1", u, rdy[u]);
        end
        set_data(u, data);
        tv[u] = 1'b1;
        tick();
        if (!hold) tv[u] = 1'b0;
        set_data(u, int'($urandom));
        for (int k = 0; k < nb; k++) begin
            eb = exp_bit(data, nbits_of(u), odd_of(u), k);
            bad_line = 0;
            bad_stat = 0;
            for (int c = 0; c < CPB; c++) begin
                if (txd[u] !== eb) bad_line++;
                if (bsy[u] !== 1'b1 || rdy[u] !== 1'b0 || dn[u] !== 1'b0) bad_stat++;
                tick();
            end
            vectors++;
            if (bad_line != 0) begin
                miscompares++;
                $display("FAIL line_bit u%0d data %h slot %0d: %0d of %0d cycles wrong, want %b",
                         u, data, k, bad_line, CPB, eb);
            end
            vectors++;
            if (bad_stat != 0) begin
                miscompares++;
                $display("FAIL busy_status u%0d data %h slot %0d: %0d bad cycles, want busy=1 ready=0 done=0",
                         u, data, k, bad_stat);
            end
        end
        vectors++;
        if ({dn[u], rdy[u], bsy[u], txd[u]} !== 4'b1101) begin
            miscompares++;
            $display("FAIL frame_end u%0d data %h: done/ready/busy/txd=%b want 1101",
                     u, data, {dn[u], rdy[u], bsy[u], txd[u]});
        end
        $display("frame u%0d data %h: %0d cycles checked", u, data, nb * CPB);
        if (!hold) begin
            tick();
            vectors++;
            if ({dn[u], rdy[u], bsy[u], txd[u]} !== 4'b0101) begin
                miscompares++;
                $display("FAIL after_done u%0d: done/ready/busy/txd=%b want 0101",
                         u, {dn[u], rdy[u], bsy[u], txd[u]});
            end
        end
    endtask

    task automatic test_reset();
        tv = 2'b11;
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tv = 2'b00;
        for (int u = 0; u < 2; u++) begin
            vectors++;
            if ({txd[u], rdy[u], bsy[u], dn[u]} !== 4'b1100) begin
                miscompares++;
                $display("FAIL reset_state u%0d: txd/ready/busy/done=%b want 1100",
                         u, {txd[u], rdy[u], bsy[u], dn[u]});
            end
        end
        $display("reset applied for 3 cycles with tx_valid high");
        tick();
    endtask

    task automatic test_known_frames();
        play_frame(0, 8'hA5, 1'b0);
        play_frame(0, 8'h07, 1'b0);
        play_frame(1, 5'h13, 1'b0);
        play_frame(1, 5'h07, 1'b0);
    endtask

    task automatic test_back_to_back();
        play_frame(0, 8'h55, 1'b1);
        play_frame(0, 8'hAA, 1'b0);
        play_frame(1, 5'h15, 1'b1);
        play_frame(1, 5'h0A, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 10; n++) begin
            int u;
            u = (n % 3 == 2) ? 1 : 0;
            repeat ($urandom_range(0, 3)) tick();
            play_frame(u, int'($urandom_range(0, 255)), 1'b0);
        end
    endtask

    // Abort a frame with reset; the line must return high with no completion pulse.
    task automatic test_reset_midframe(input int data, input int at_cycle);
        int bad;
        td8 = data[7:0];
        tv[0] = 1'b1;
        tick();
        tv[0] = 1'b0;
        repeat (at_cycle - 1) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vectors++;
        if ({txd[0], rdy[0], bsy[0], dn[0]} !== 4'b1100) begin
            miscompares++;
            $display("FAIL midframe_reset data %h cycle %0d: txd/ready/busy/done=%b want 1100",
                     data, at_cycle, {txd[0], rdy[0], bsy[0], dn[0]});
        end
        bad = 0;
        for (int c = 0; c < 3 * CPB; c++) begin
            tick();
            if (dn[0] !== 1'b0 || txd[0] !== 1'b1) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL post_abort_idle data %h: %0d cycles with done!=0 or txd!=1, want 0", data, bad);
        end
        $display("reset at cycle %0d of frame data %h", at_cycle, data);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "timeout");
    end

    initial begin
        tick();
        test_reset();
        test_known_frames();
        test_back_to_back();
        test_random();
        test_reset_midframe(8'hFF, 45);
        test_reset_midframe(8'h00, int'($urandom_range(2, 95)));
        play_frame(0, 8'h3C, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_tx_param.md
UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 Parameter CLK_FREQ_HZ, default 100000000, input clock frequency in Hz.
REQ-002 Parameter BAUD, default 9600, line rate in bit/s.
REQ-003 Parameter DATA_BITS, default 8, data bits per frame; legal range 5..9.
REQ-004 Parameter STOP_BITS, default 1, stop bits per frame; legal values 1 or 2.
REQ-005 Parameter PARITY_ODD, default 0, parity sense: 0 = even, 1 = odd; used only under UART_TX_PARITY_EN.
REQ-006 clk  input  1  single clock; all logic on rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 tx_valid  input  1  producer has a character on tx_data.
REQ-009 tx_data  input  DATA_BITS  character to send, LSB first.
REQ-010 tx_ready  output  1  block can accept a character this cycle.
REQ-011 TxD  output  1  serial line; idle high.
REQ-012 tx_busy  output  1  frame in progress.
REQ-013 tx_done  output  1  one-cycle pulse on frame completion.

Function
REQ-014 CLKS_PER_BIT SHALL equal CLK_FREQ_HZ/BAUD rounded to nearest; baud counter width SHALL be $clog2(CLKS_PER_BIT); counter wraps to 0 at CLKS_PER_BIT-1.
REQ-015 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; undefined encodings SHALL return to IDLE.
REQ-016 tx_ready SHALL be 1 only in IDLE; tx_busy SHALL equal NOT tx_ready; all outputs registered.
REQ-017 Accept occurs when tx_valid and tx_ready are both high on a rising edge; tx_data captured into shift register that edge; tx_valid while not ready SHALL be ignored.
REQ-018 Transitions: IDLE->START on accept; START->DATA after 1 bit time; DATA->PARITY (macro on) or STOP after DATA_BITS bit times; PARITY->STOP after 1 bit time; STOP->IDLE after STOP_BITS bit times.
REQ-019 TxD SHALL go low the cycle after accept; every bit SHALL be held exactly CLKS_PER_BIT cycles.
REQ-020 Data bits SHALL be sent LSB first; tx_data changes after accept SHALL not affect the frame.
REQ-021 tx_done SHALL pulse for exactly one cycle, the first IDLE cycle after STOP, coincident with tx_ready rising.
REQ-022 Back-to-back: tx_valid held high SHALL be accepted in that first IDLE cycle; exactly one idle-high clock separates frames.
REQ-023 Frame length SHALL be (1+DATA_BITS+P+STOP_BITS)*CLKS_PER_BIT cycles, P = 1 with parity else 0.

Reset
REQ-024 On reset: state IDLE, TxD=1, tx_ready=1, tx_busy=0, tx_done=0, baud and bit counters 0.
REQ-025 Reset mid-frame SHALL abort the frame; TxD high on the next cycle; no tx_done pulse.
REQ-026 Reset SHALL take priority over simultaneous accept.

Configuration
REQ-027 Macro UART_TX_PARITY_EN defined: PARITY state inserted; parity bit = XOR of data bits XOR PARITY_ODD, sent after last data bit for one bit time.
REQ-028 Macro undefined: no PARITY state, no parity logic, PARITY_ODD ignored, STOP follows DATA directly.

Verification (CLK_FREQ_HZ=1000000, BAUD=100000 -> 10 clk/bit unless noted)
REQ-029 Assert reset 3 cycles -> TxD=1, tx_ready=1, tx_busy=0, tx_done=0.
REQ-030 No macro, send 0xA5 -> TxD 0,1,0,1,0,0,1,0,1,1 each 10 cycles; tx_done at cycle 101 after accept.
REQ-031 Macro on, send 0x07: PARITY_ODD=0 -> parity bit 1; PARITY_ODD=1 -> parity bit 0; frame 110 cycles.
REQ-032 tx_valid held high, data 0x55 then 0xAA -> two frames, exactly one idle-high cycle between, tx_data change mid-frame ignored.
REQ-033 Reset asserted at cycle 45 of a 0xFF frame -> TxD=1 next cycle, tx_ready=1, no tx_done.
REQ-034 DATA_BITS=5, STOP_BITS=2, send 0x13 -> TxD 0,1,1,0,0,1,1,1; frame 80 cycles (no macro).
